// File: rtl/result_converter.sv
// result_converter: turns quadrant-corrected CORDIC fixed-point sin/cos into IEEE754 singles
module result_converter #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] sin_in,
  input  logic signed [WIDTH-1:0] cos_in,
  input  logic signed [2:0]       flips,
  output logic [31:0]             sin_out,
  output logic [31:0]             cos_out,
  output logic                    done,
  output logic                    ready
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, NORM = 2'd2, PACK = 2'd3;
  localparam logic [7:0] EB = 8'(127 + WIDTH - 1 - FRAC);
  logic [1:0] state, q;
  logic [WIDTH-1:0] s_raw, c_raw, s_mag, c_mag, sn_mag, cn_mag;
  logic s_sgn, c_sgn, sn_neg, cn_neg, s_ok, c_ok;
  logic [4:0] s_sh, c_sh;
  logic unused_flips;
  assign unused_flips = flips[2];
  always_comb begin
    sn_neg = s_raw[WIDTH-1];
    cn_neg = c_raw[WIDTH-1];
    sn_mag = sn_neg ? -s_raw : s_raw;
    cn_mag = cn_neg ? -c_raw : c_raw;
    s_ok = s_mag == '0 || s_mag[WIDTH-1];
    c_ok = c_mag == '0 || c_mag[WIDTH-1];
  end
  function automatic logic [31:0] pack(input logic sg, input logic [WIDTH-1:0] m, input logic [4:0] sh);
    return m == '0 ? 32'd0 : {sg, EB - 8'(sh), m[WIDTH-2 -: 23]};
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done <= 1'b0;
      sin_out <= '0;
      cos_out <= '0;
      s_raw <= '0;
      c_raw <= '0;
      q <= '0;
      s_mag <= '0;
      c_mag <= '0;
      s_sgn <= 1'b0;
      c_sgn <= 1'b0;
      s_sh <= '0;
      c_sh <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          s_raw <= sin_in;
          c_raw <= cos_in;
          q <= flips[1:0];
          ready <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          // negating a term flips its sign; the magnitude is shared with the uncorrected value
          s_sgn <= q == 2'd0 ? sn_neg : q == 2'd1 ? ~cn_neg : q == 2'd2 ? ~sn_neg : cn_neg;
          c_sgn <= q == 2'd0 ? cn_neg : q == 2'd1 ? sn_neg : q == 2'd2 ? ~cn_neg : ~sn_neg;
          s_mag <= q[0] ? cn_mag : sn_mag;
          c_mag <= q[0] ? sn_mag : cn_mag;
          s_sh <= '0;
          c_sh <= '0;
          state <= NORM;
        end
        NORM: begin
          if (s_ok && c_ok) state <= PACK;
          if (!s_ok) begin
            s_mag <= s_mag << 1;
            s_sh <= s_sh + 5'd1;
          end
          if (!c_ok) begin
            c_mag <= c_mag << 1;
            c_sh <= c_sh + 5'd1;
          end
        end
        default: begin
          sin_out <= pack(s_sgn, s_mag, s_sh);
          cos_out <= pack(c_sgn, c_mag, c_sh);
          done <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
